// File: rtl/ahbl_sram_slave_if.sv
// ahbl_sram_slave_if: AHB-Lite signal bundle between a bus master/interconnect and one slave.
interface ahbl_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    modport master (output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
                    input hreadyout, hresp, hrdata);
    modport slave  (input hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
                    output hreadyout, hresp, hrdata);
endinterface

// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave: AHB-Lite slave over a word-organised SRAM with wait states, two-cycle ERROR and write-to-read forwarding.
module ahbl_sram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input logic               clk,
    input logic               rstn,
    ahbl_sram_slave_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W+1:0] a_addr;
    logic [1:0]        a_size;
    logic              wr_pend;
    logic [31:0]       mem [2**ADDR_W];
    logic              accept, err, commit;
    logic [3:0]        strb;
    logic [31:0]       wmask, rd_word;
    logic [ADDR_W-1:0] rd_idx, wr_idx;
    logic              unused;

    assign accept = bus.hsel & bus.hready & bus.htrans[1] & (state == IDLE || state == ERR2);
    assign err = bus.hsize > 3'd2 || (bus.hsize == 3'd1 && bus.haddr[0]) ||
                 (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'd0);
    // A pending write commits on the final (ready) data-phase cycle, which is always an IDLE cycle.
    assign commit = wr_pend & (state == IDLE);
    assign strb = a_size == 2'd0 ? 4'b0001 << a_addr[1:0] :
                  a_size == 2'd1 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wmask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    assign rd_idx = bus.haddr[ADDR_W+1:2];
    assign wr_idx = a_addr[ADDR_W+1:2];
    assign rd_word = commit && rd_idx == wr_idx ? (bus.hwdata & wmask) | (mem[rd_idx] & ~wmask) : mem[rd_idx];
    assign unused = ^{bus.haddr[31:ADDR_W+2], bus.htrans[0]};

    always_ff @(posedge clk)
        if (commit) mem[wr_idx] <= (bus.hwdata & wmask) | (mem[wr_idx] & ~wmask);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            a_addr        <= '0;
            a_size        <= 2'd0;
            wr_pend       <= 1'b0;
            bus.hreadyout <= 1'b1;
            bus.hresp     <= 1'b0;
            bus.hrdata    <= 32'd0;
        end else begin
            if (commit) wr_pend <= 1'b0;
            if (accept) begin
                a_addr        <= bus.haddr[ADDR_W+1:0];
                a_size        <= bus.hsize[1:0];
                wr_pend       <= bus.hwrite & ~err;
                if (!bus.hwrite && !err) bus.hrdata <= rd_word;
                state         <= err ? ERR1 : WAIT_STATES > 0 ? WAIT : IDLE;
                cnt           <= err || WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
                bus.hreadyout <= !err && WAIT_STATES == 0;
                bus.hresp     <= err;
            end else begin
                case (state)
                    ERR1: begin
                        state         <= ERR2;
                        bus.hreadyout <= 1'b1;
                        bus.hresp     <= 1'b1;
                    end
                    WAIT: begin
                        cnt           <= cnt - 4'd1;
                        state         <= cnt == 4'd0 ? IDLE : WAIT;
                        bus.hreadyout <= cnt == 4'd0;
                        bus.hresp     <= 1'b0;
                    end
                    default: begin
                        state         <= IDLE;
                        bus.hreadyout <= 1'b1;
                        bus.hresp     <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// tb_ahbl_sram_slave: directed checks of two slaves (0 and 3 wait states) on private buses.
module tb_ahbl_sram_slave;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hsel0 = 1'b0, hsel3 = 1'b0, stall = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] rd;
    int          w;
    logic        r1, rf;

    ahbl_sram_slave_if b0 ();
    ahbl_sram_slave_if b3 ();
    assign b0.hsel = hsel0;
    assign b3.hsel = hsel3;
    assign {b0.haddr, b0.htrans, b0.hwrite, b0.hsize, b0.hwdata} = {haddr, htrans, hwrite, hsize, hwdata};
    assign {b3.haddr, b3.htrans, b3.hwrite, b3.hsize, b3.hwdata} = {haddr, htrans, hwrite, hsize, hwdata};
    // Each slave sees its own hreadyout as bus ready; stall models another slave holding the bus.
    assign b0.hready = b0.hreadyout;
    assign b3.hready = b3.hreadyout & ~stall;

    ahbl_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) u0 (.clk(clk), .rstn(rstn), .bus(b0));
    ahbl_sram_slave #(.ADDR_W(10), .WAIT_STATES(3)) u3 (.clk(clk), .rstn(rstn), .bus(b3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit d, input logic [31:0] a, input bit wr, input logic [2:0] s,
                        input logic [31:0] wd, output logic [31:0] rdat, output int waits,
                        output logic resp1, output logic respf);
        haddr = a; hwrite = wr; hsize = s; htrans = 2'd2;
        if (d) hsel3 = 1'b1; else hsel0 = 1'b1;
        @(posedge clk); #1;
        htrans = 2'd0; hsel0 = 1'b0; hsel3 = 1'b0; hwdata = wd;
        resp1 = d ? b3.hresp : b0.hresp;
        waits = 0;
        while (!(d ? b3.hreadyout : b0.hreadyout) && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        rdat = d ? b3.hrdata : b0.hrdata;
        respf = d ? b3.hresp : b0.hresp;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", b0.hreadyout, 1);
        chk("rst_resp", b0.hresp, 0);
        chk("rst_rdata", b0.hrdata, 0);
        chk("rst_rdy3", b3.hreadyout, 1);
        rstn = 1'b1;
        @(posedge clk); #1;

        xfer(0, 32'h10, 1, 3'd2, 32'hDEADBEEF, rd, w, r1, rf);
        xfer(0, 32'h10, 0, 3'd2, 32'h0, rd, w, r1, rf);
        chk("word_rd", rd, 32'hDEADBEEF);
        chk("word_resp", rf, 0);
        chk("word_waits", w, 0);

        xfer(0, 32'h20, 1, 3'd2, 32'h11223344, rd, w, r1, rf);
        xfer(0, 32'h21, 1, 3'd0, 32'h0000AA00, rd, w, r1, rf);
        xfer(0, 32'h22, 1, 3'd1, 32'hBBCC0000, rd, w, r1, rf);
        xfer(0, 32'h20, 0, 3'd2, 32'h0, rd, w, r1, rf);
        chk("lanes", rd, 32'hBBCCAA44);

        xfer(0, 32'h30, 1, 3'd2, 32'h01020304, rd, w, r1, rf);
        haddr = 32'h31; hwrite = 1'b1; hsize = 3'd0; htrans = 2'd2; hsel0 = 1'b1;
        @(posedge clk); #1;
        chk("fwd_wr_rdy", b0.hreadyout, 1);
        hwdata = 32'h00005A00; haddr = 32'h30; hwrite = 1'b0; hsize = 3'd2;
        @(posedge clk); #1;
        htrans = 2'd0; hsel0 = 1'b0;
        chk("fwd_rdata", b0.hrdata, 32'h01025A04);
        chk("fwd_rd_rdy", b0.hreadyout, 1);
        @(posedge clk); #1;
        xfer(0, 32'h30, 0, 3'd2, 32'h0, rd, w, r1, rf);
        chk("fwd_mem", rd, 32'h01025A04);

        xfer(0, 32'h40, 1, 3'd2, 32'hCAFEF00D, rd, w, r1, rf);
        xfer(0, 32'h42, 1, 3'd2, 32'h12345678, rd, w, r1, rf);
        chk("err_waits", w, 1);
        chk("err_resp1", r1, 1);
        chk("err_resp2", rf, 1);
        xfer(0, 32'h40, 0, 3'd2, 32'h0, rd, w, r1, rf);
        chk("err_mem", rd, 32'hCAFEF00D);
        xfer(0, 32'h40, 1, 3'd3, 32'hFFFFFFFF, rd, w, r1, rf);
        chk("sz3_waits", w, 1);
        chk("sz3_resp1", r1, 1);
        chk("sz3_resp2", rf, 1);
        xfer(0, 32'h41, 0, 3'd1, 32'h0, rd, w, r1, rf);
        chk("err_rd_hold", rd, 32'hCAFEF00D);
        xfer(0, 32'h40, 0, 3'd2, 32'h0, rd, w, r1, rf);
        chk("sz3_mem", rd, 32'hCAFEF00D);

        xfer(0, 32'h1000, 1, 3'd2, 32'h77, rd, w, r1, rf);
        xfer(0, 32'h0, 0, 3'd2, 32'h0, rd, w, r1, rf);
        chk("alias", rd, 32'h77);

        xfer(1, 32'h10, 1, 3'd2, 32'h0BADF00D, rd, w, r1, rf);
        chk("ws_wr_waits", w, 3);
        haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd2; hsel3 = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_rdy", b3.hreadyout, 1);
        end
        hsel3 = 1'b0; htrans = 2'd0; stall = 1'b0;
        xfer(1, 32'h10, 0, 3'd2, 32'h0, rd, w, r1, rf);
        chk("ws_rd_waits", w, 3);
        chk("ws_rd", rd, 32'h0BADF00D);
        chk("ws_rd_resp", rf, 0);
        xfer(1, 32'h13, 0, 3'd2, 32'h0, rd, w, r1, rf);
        chk("ws_err_waits", w, 1);

        xfer(1, 32'h50, 1, 3'd2, 32'h55, rd, w, r1, rf);
        haddr = 32'h50; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2; hsel3 = 1'b1;
        @(posedge clk); #1;
        htrans = 2'd0; hsel3 = 1'b0; hwdata = 32'hAAAAAAAA;
        chk("rst_wait_rdy", b3.hreadyout, 0);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_rdy", b3.hreadyout, 1);
        chk("rst_async_rdata", b3.hrdata, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        xfer(1, 32'h50, 0, 3'd2, 32'h0, rd, w, r1, rf);
        chk("rst_drop_wr", rd, 32'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
